// File: rtl/vcve2_vlsu_pkg.sv
// Shared types and constants for the vector load/store address generator.
package vcve2_vlsu_pkg;

    localparam int unsigned AddrW            = 32;
    localparam int unsigned DataW            = 32;
    localparam int unsigned ElemBytesDefault = 4;
    localparam int unsigned StateW           = 2;

    typedef logic [StateW-1:0] vlsu_state_t;

    localparam vlsu_state_t StIdle       = 2'd0;
    localparam vlsu_state_t StWaitScalar = 2'd1;
    localparam vlsu_state_t StIssue      = 2'd2;
    localparam vlsu_state_t StDrain      = 2'd3;

    typedef enum logic {
        ModeUnit    = 1'b0,
        ModeStrided = 1'b1
    } vlsu_mode_e;

    // Per-op configuration captured on start.
    typedef struct packed {
        logic [AddrW-1:0] stride;
        vlsu_mode_e       mode;
        logic             is_store;
    } vlsu_cfg_t;

    // Address increment between consecutive elements.
    function automatic logic [AddrW-1:0] vlsu_step(input vlsu_mode_e       mode,
                                                   input logic [AddrW-1:0] stride,
                                                   input int unsigned      elem_bytes);
        return (mode == ModeStrided) ? stride : AddrW'(elem_bytes);
    endfunction

endpackage

// File: rtl/vcve2_vlsu_outstanding_cnt.sv
// Saturating up/down counter of LSU transactions granted but not yet answered.
module vcve2_vlsu_outstanding_cnt #(
    parameter int unsigned MaxCnt = 2,
    localparam int unsigned CntW  = $clog2(MaxCnt + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            eff_inc, eff_dec;

    assign full_o  = (cnt_q == CntW'(MaxCnt));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

    // A response with nothing in flight is dropped rather than underflowing.
    assign eff_dec = dec_i && !empty_o;
    assign eff_inc = inc_i && (!full_o || eff_dec);

    always_comb begin
        cnt_d = cnt_q;
        if (eff_inc && !eff_dec) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (eff_dec && !eff_inc) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) dec_i |-> !empty_o)
        else $error("outstanding counter: response with no transaction in flight");

endmodule

// File: rtl/vcve2_vlsu_agu.sv
// Vector load/store address generator and LSU arbiter between scalar and vector traffic.
module vcve2_vlsu_agu
    import vcve2_vlsu_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned ElemCntW       = 8,
    parameter int unsigned ElemBytes      = ElemBytesDefault
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [AddrW-1:0]    start_addr_i,
    input  logic [AddrW-1:0]    stride_i,
    input  logic                strided_i,
    input  logic [ElemCntW-1:0] vl_i,
    input  logic                is_store_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic                vrf_req_i,
    input  logic [DataW-1:0]    vrf_data_i,
    output logic                vrf_gnt_o,
    output logic                vrf_wvalid_o,
    output logic [DataW-1:0]    vrf_wdata_o,
    input  logic                scalar_req_i,
    input  logic                scalar_we_i,
    input  logic [AddrW-1:0]    scalar_addr_i,
    input  logic [DataW-1:0]    scalar_wdata_i,
    output logic                scalar_gnt_o,
    output logic                scalar_rvalid_o,
    output logic                lsu_req_o,
    output logic                lsu_we_o,
    output logic [AddrW-1:0]    lsu_addr_o,
    output logic [DataW-1:0]    lsu_wdata_o,
    input  logic                lsu_gnt_i,
    input  logic                lsu_rvalid_i,
    input  logic [DataW-1:0]    lsu_rdata_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    vlsu_state_t         state_q, state_d;
    logic [AddrW-1:0]    addr_q, addr_d;
    logic [ElemCntW-1:0] issued_q, issued_d;
    logic [ElemCntW-1:0] vl_q, vl_d;
    vlsu_cfg_t           cfg_q, cfg_d;
    logic                scalar_pending_q, scalar_pending_d;
    logic                done_q, done_d;

    logic                vec_gnt, vec_rsp, last_rsp;
    logic                cnt_full, cnt_empty;
    logic [CntW-1:0]     cnt;

    vcve2_vlsu_outstanding_cnt #(
        .MaxCnt (MaxOutstanding)
    ) u_outstanding (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (vec_gnt),
        .dec_i   (vec_rsp),
        .cnt_o   (cnt),
        .full_o  (cnt_full),
        .empty_o (cnt_empty)
    );

    assign busy_o   = (state_q != StIdle);
    assign done_o   = done_q;
    assign vec_gnt  = (state_q == StIssue) && lsu_req_o && lsu_gnt_i;
    assign vec_rsp  = ((state_q == StIssue) || (state_q == StDrain)) && lsu_rvalid_i;
    assign last_rsp = cnt_empty || ((cnt == CntW'(1)) && vec_rsp);

    // Bus steering; everything is held quiet while reset is asserted.
    always_comb begin
        lsu_req_o       = 1'b0;
        lsu_we_o        = 1'b0;
        lsu_addr_o      = '0;
        lsu_wdata_o     = '0;
        scalar_gnt_o    = 1'b0;
        scalar_rvalid_o = 1'b0;
        vrf_gnt_o       = 1'b0;
        vrf_wvalid_o    = 1'b0;
        vrf_wdata_o     = '0;
        if (rst_ni) begin
            case (state_q)
                StIdle: begin
                    lsu_req_o       = scalar_req_i && !start_i;
                    lsu_we_o        = scalar_we_i;
                    lsu_addr_o      = scalar_addr_i;
                    lsu_wdata_o     = scalar_wdata_i;
                    scalar_gnt_o    = lsu_req_o && lsu_gnt_i;
                    scalar_rvalid_o = lsu_rvalid_i;
                end
                StWaitScalar: begin
                    scalar_rvalid_o = lsu_rvalid_i;
                end
                StIssue: begin
                    lsu_req_o    = !cnt_full && (!cfg_q.is_store || vrf_req_i);
                    lsu_we_o     = cfg_q.is_store;
                    lsu_addr_o   = addr_q;
                    lsu_wdata_o  = vrf_data_i;
                    vrf_gnt_o    = lsu_req_o && lsu_gnt_i && cfg_q.is_store;
                    vrf_wvalid_o = lsu_rvalid_i && !cfg_q.is_store;
                    vrf_wdata_o  = lsu_rdata_i;
                end
                StDrain: begin
                    vrf_wvalid_o = lsu_rvalid_i && !cfg_q.is_store;
                    vrf_wdata_o  = lsu_rdata_i;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        issued_d         = issued_q;
        vl_d             = vl_q;
        cfg_d            = cfg_q;
        scalar_pending_d = scalar_pending_q;
        done_d           = 1'b0;
        case (state_q)
            StIdle: begin
                if (scalar_gnt_o) begin
                    scalar_pending_d = 1'b1;
                end else if (lsu_rvalid_i) begin
                    scalar_pending_d = 1'b0;
                end
                if (start_i) begin
                    addr_d         = start_addr_i;
                    issued_d       = '0;
                    vl_d           = vl_i;
                    cfg_d.stride   = stride_i;
                    cfg_d.mode     = vlsu_mode_e'(strided_i);
                    cfg_d.is_store = is_store_i;
                    if (vl_i == '0) begin
                        done_d = 1'b1;
                    end else if (scalar_pending_d) begin
                        state_d = StWaitScalar;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StWaitScalar: begin
                if (lsu_rvalid_i) begin
                    scalar_pending_d = 1'b0;
                    state_d          = StIssue;
                end
            end
            StIssue: begin
                if (vec_gnt) begin
                    addr_d   = addr_q + vlsu_step(cfg_q.mode, cfg_q.stride, ElemBytes);
                    issued_d = issued_q + ElemCntW'(1);
                    if (issued_q == vl_q - ElemCntW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_rsp) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            addr_q           <= '0;
            issued_q         <= '0;
            vl_q             <= '0;
            cfg_q            <= '0;
            scalar_pending_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            issued_q         <= issued_d;
            vl_q             <= vl_d;
            cfg_q            <= cfg_d;
            scalar_pending_q <= scalar_pending_d;
            done_q           <= done_d;
        end
    end

endmodule

// File: tb/tb_vcve2_vlsu_agu.sv
// Self-checking bench for vcve2_vlsu_agu: directed op table, random ops, reset and scalar sequences.
module tb_vcve2_vlsu_agu;

    localparam int MaxOut = 2;
    localparam int Budget = 3000;

    logic        clk, rst_ni;
    logic        start_i, strided_i, is_store_i;
    logic [31:0] start_addr_i, stride_i;
    logic [7:0]  vl_i;
    logic        busy_o, done_o;
    logic        vrf_req_i, vrf_gnt_o, vrf_wvalid_o;
    logic [31:0] vrf_data_i, vrf_wdata_o;
    logic        scalar_req_i, scalar_we_i, scalar_gnt_o, scalar_rvalid_o;
    logic [31:0] scalar_addr_i, scalar_wdata_i;
    logic        lsu_req_o, lsu_we_o, lsu_gnt_i, lsu_rvalid_i;
    logic [31:0] lsu_addr_o, lsu_wdata_o, lsu_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    vcve2_vlsu_agu #(
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .start_addr_i    (start_addr_i),
        .stride_i        (stride_i),
        .strided_i       (strided_i),
        .vl_i            (vl_i),
        .is_store_i      (is_store_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .vrf_req_i       (vrf_req_i),
        .vrf_data_i      (vrf_data_i),
        .vrf_gnt_o       (vrf_gnt_o),
        .vrf_wvalid_o    (vrf_wvalid_o),
        .vrf_wdata_o     (vrf_wdata_o),
        .scalar_req_i    (scalar_req_i),
        .scalar_we_i     (scalar_we_i),
        .scalar_addr_i   (scalar_addr_i),
        .scalar_wdata_i  (scalar_wdata_i),
        .scalar_gnt_o    (scalar_gnt_o),
        .scalar_rvalid_o (scalar_rvalid_o),
        .lsu_req_o       (lsu_req_o),
        .lsu_we_o        (lsu_we_o),
        .lsu_addr_o      (lsu_addr_o),
        .lsu_wdata_o     (lsu_wdata_o),
        .lsu_gnt_i       (lsu_gnt_i),
        .lsu_rvalid_i    (lsu_rvalid_i),
        .lsu_rdata_i     (lsu_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] stride;
        bit          strided;
        bit          store;
        int          vl;
        int          gnt_pct;
        int          lat;
        int          vrf_pct;
        int          scal;      // >0: scalar access pending at start, answered on this cycle
        bit          chk_last;
        logic [31:0] exp_last;  // hand-computed address of the final element
    } op_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing store contents seen by loads.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic idle_inputs();
        start_i = 1'b0; strided_i = 1'b0; is_store_i = 1'b0;
        start_addr_i = '0; stride_i = '0; vl_i = '0;
        vrf_req_i = 1'b0; vrf_data_i = '0;
        scalar_req_i = 1'b0; scalar_we_i = 1'b0; scalar_addr_i = '0; scalar_wdata_i = '0;
        lsu_gnt_i = 1'b0; lsu_rvalid_i = 1'b0; lsu_rdata_i = '0;
    endtask

    // One scalar read granted in IDLE, response left outstanding.
    task automatic scalar_pregrant();
        logic [31:0] a;
        @(negedge clk);
        a = $urandom;
        scalar_req_i = 1'b1; scalar_we_i = 1'b0; scalar_addr_i = a;
        #1;
        chk("pre_lsu_req", 32'(lsu_req_o), 32'd1);
        chk("pre_lsu_addr", lsu_addr_o, a);
        lsu_gnt_i = 1'b1;
        #1;
        chk("pre_scalar_gnt", 32'(scalar_gnt_o), 32'd1);
        @(posedge clk);
    endtask

    task automatic run_op(input op_t op);
        logic [31:0] step, rsp_addr, last_addr;
        logic [31:0] ea[$];
        logic [31:0] sd[$];
        int          rq_cyc[$];
        logic [31:0] rq_addr[$];
        int          c, granted, answered, nout, done_cycle, issue_start, n_vgnt, n_wv;
        bit          fin, grant, rv, srsp, vreq, exp_req, exp_busy;

        step = op.strided ? op.stride : 32'd4;
        for (int i = 0; i < op.vl; i++) begin
            ea.push_back(op.base + step * 32'(i));
            sd.push_back($urandom);
        end
        issue_start = (op.scal > 0) ? op.scal + 1 : 1;
        done_cycle  = (op.vl == 0) ? 1 : -1;
        granted = 0; answered = 0; nout = 0; n_vgnt = 0; n_wv = 0;
        last_addr = '0; c = 0; fin = 1'b0;

        while (!fin) begin
            @(negedge clk);
            start_i = (c == 0);
            if (c == 0) begin
                start_addr_i = op.base; stride_i = op.stride; strided_i = op.strided;
                vl_i = 8'(op.vl); is_store_i = op.store;
            end
            scalar_req_i  = (op.scal > 0) && (c != done_cycle);
            scalar_addr_i = $urandom;
            vreq = ($urandom_range(99) < op.vrf_pct);
            vrf_req_i  = vreq;
            vrf_data_i = (granted < op.vl) ? sd[granted] : 32'h0;
            srsp = (op.scal > 0) && (c == op.scal);
            rv = srsp;
            rsp_addr = '0;
            if (!srsp && rq_cyc.size() > 0) begin
                if (rq_cyc[0] <= c) begin
                    rv = 1'b1;
                    rsp_addr = rq_addr[0];
                end
            end
            lsu_rvalid_i = rv;
            lsu_rdata_i  = srsp ? $urandom : mem_rd(rsp_addr);
            lsu_gnt_i    = 1'b0;
            #1;
            exp_req = (c >= issue_start) && (granted < op.vl) && (nout < MaxOut) && (!op.store || vreq);
            if (c > 0) chk("lsu_req", 32'(lsu_req_o), 32'(exp_req));
            grant = lsu_req_o && (c >= issue_start) && ($urandom_range(99) < op.gnt_pct);
            lsu_gnt_i = grant;
            #1;
            if (grant && granted < op.vl) begin
                chk("lsu_addr", lsu_addr_o, ea[granted]);
                chk("lsu_we", 32'(lsu_we_o), 32'(op.store));
                if (op.store) chk("lsu_wdata", lsu_wdata_o, sd[granted]);
                last_addr = lsu_addr_o;
                rq_cyc.push_back(c + op.lat);
                rq_addr.push_back(ea[granted]);
                granted++;
            end
            chk("vrf_gnt", 32'(vrf_gnt_o), 32'(grant && op.store));
            if (vrf_gnt_o) n_vgnt++;
            chk("vrf_wvalid", 32'(vrf_wvalid_o), 32'(rv && !srsp && !op.store));
            if (vrf_wvalid_o) begin
                n_wv++;
                chk("vrf_wdata", vrf_wdata_o, mem_rd(rsp_addr));
            end
            chk("scalar_rvalid", 32'(scalar_rvalid_o), 32'(srsp));
            chk("scalar_gnt_blocked", 32'(scalar_gnt_o), 32'd0);
            exp_busy = (c >= 1) && ((done_cycle < 0) || (c < done_cycle));
            chk("busy", 32'(busy_o), 32'(exp_busy));
            chk("done", 32'(done_o), 32'(c == done_cycle));
            if (rv && !srsp) begin
                void'(rq_cyc.pop_front());
                void'(rq_addr.pop_front());
                answered++;
            end
            nout = nout + (grant ? 1 : 0) - ((rv && !srsp) ? 1 : 0);
            if (c == done_cycle) begin
                fin = 1'b1;
            end else begin
                if (op.vl > 0 && answered == op.vl && done_cycle < 0) done_cycle = c + 1;
                if (c >= Budget) begin
                    chk("op_timeout", 32'(c), 32'(Budget + 1));
                    fin = 1'b1;
                end
                @(posedge clk);
                c++;
            end
        end
        if (op.chk_last && op.vl > 0) chk("last_addr", last_addr, op.exp_last);
        chk("vrf_gnt_count", 32'(n_vgnt), op.store ? 32'(op.vl) : 32'd0);
        chk("vrf_wvalid_count", 32'(n_wv), op.store ? 32'd0 : 32'(op.vl));
        idle_inputs();
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        start_i = 1'b1; start_addr_i = 32'h6000; stride_i = '0; strided_i = 1'b0;
        vl_i = 8'd8; is_store_i = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            lsu_gnt_i = lsu_req_o;
            @(posedge clk);
        end
        @(negedge clk);
        lsu_gnt_i = 1'b0;
        #1;
        chk("rst_pre_busy", 32'(busy_o), 32'd1);
        scalar_req_i = 1'b1; lsu_rvalid_i = 1'b1; lsu_gnt_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_lsu_req", 32'(lsu_req_o), 32'd0);
        chk("rst_async_busy", 32'(busy_o), 32'd0);
        chk("rst_async_done", 32'(done_o), 32'd0);
        chk("rst_async_vrf_gnt", 32'(vrf_gnt_o), 32'd0);
        chk("rst_async_vrf_wvalid", 32'(vrf_wvalid_o), 32'd0);
        chk("rst_async_scalar_gnt", 32'(scalar_gnt_o), 32'd0);
        chk("rst_async_scalar_rvalid", 32'(scalar_rvalid_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_ni = 1'b1;
        @(negedge clk);
        scalar_req_i = 1'b1; scalar_we_i = 1'b1;
        scalar_addr_i = 32'hABCD_0000; scalar_wdata_i = 32'h1234_5678;
        #1;
        chk("post_rst_lsu_req", 32'(lsu_req_o), 32'd1);
        chk("post_rst_lsu_we", 32'(lsu_we_o), 32'd1);
        chk("post_rst_lsu_addr", lsu_addr_o, 32'hABCD_0000);
        chk("post_rst_lsu_wdata", lsu_wdata_o, 32'h1234_5678);
        lsu_gnt_i = 1'b1;
        #1;
        chk("post_rst_scalar_gnt", 32'(scalar_gnt_o), 32'd1);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        scalar_req_i = 1'b0; lsu_gnt_i = 1'b0; lsu_rvalid_i = 1'b1;
        #1;
        chk("post_rst_scalar_rvalid", 32'(scalar_rvalid_o), 32'd1);
        chk("post_rst_vrf_wvalid", 32'(vrf_wvalid_o), 32'd0);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        op_t dir[7];
        op_t r;

        dir[0] = '{32'h0000_1000, 32'h0,         1'b0, 1'b0, 4, 100, 1, 100, 0, 1'b1, 32'h0000_100C};
        dir[1] = '{32'h0000_2000, 32'hFFFF_FFF8, 1'b1, 1'b1, 3, 100, 1,  50, 0, 1'b1, 32'h0000_1FF0};
        dir[2] = '{32'h0000_3000, 32'h0,         1'b0, 1'b0, 6, 100, 5, 100, 0, 1'b1, 32'h0000_3014};
        dir[3] = '{32'h0000_4000, 32'h0000_0010, 1'b1, 1'b0, 3, 100, 2, 100, 2, 1'b1, 32'h0000_4020};
        dir[4] = '{32'h0000_5000, 32'h0,         1'b0, 1'b0, 0, 100, 1, 100, 0, 1'b1, 32'h0};
        dir[5] = '{32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0, 2, 100, 1, 100, 0, 1'b1, 32'h0000_0000};
        dir[6] = '{32'h0000_0100, 32'h0000_0010, 1'b1, 1'b1, 5,  60, 3,  70, 0, 1'b1, 32'h0000_0140};

        idle_inputs();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_lsu_req", 32'(lsu_req_o), 32'd0);
        chk("reset_vrf_wvalid", 32'(vrf_wvalid_o), 32'd0);
        chk("reset_scalar_gnt", 32'(scalar_gnt_o), 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (dir[i].scal > 0) scalar_pregrant();
            run_op(dir[i]);
        end

        for (int i = 0; i < 40; i++) begin
            r.vl       = $urandom_range(12);
            r.store    = 1'($urandom_range(1));
            r.strided  = 1'($urandom_range(1));
            r.stride   = 32'($urandom_range(63) * 4) - 32'd128;
            r.base     = ($urandom_range(4) == 0) ? 32'hFFFF_FFF0 : $urandom;
            r.gnt_pct  = $urandom_range(100, 30);
            r.lat      = $urandom_range(6, 1);
            r.vrf_pct  = $urandom_range(100, 30);
            r.scal     = (r.vl > 0 && $urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
            r.chk_last = 1'b0;
            r.exp_last = '0;
            if (r.scal > 0) scalar_pregrant();
            run_op(r);
        end

        reset_mid_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vcve2_vlsu_agu.md
Name: vcve2_vlsu_agu

Overview:
Parametrised vector load/store address generator and LSU arbiter, between the ID/EX stage, the VRF and the shared data-side LSU. Supports unit-stride and constant-stride modes, a programmable element count and up to MaxOutstanding in-flight LSU transactions. Runs the whole vector memory op autonomously and signals completion. Scalar accesses pass through only when no vector op is active.

Parameters:
MaxOutstanding, 2, max LSU requests granted but not yet answered (>=1)
ElemCntW, 8, width of vector element count (vl up to 2**ElemCntW-1)
ElemBytes, 4, byte increment per element in unit-stride mode

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start vector mem op (one-cycle pulse)
start_addr_i  in  32  base address
stride_i  in  32  byte stride, two's complement, used when strided_i=1
strided_i  in  1  0 unit-stride, 1 constant-stride
vl_i  in  ElemCntW  element count
is_store_i  in  1  1 store, 0 load
busy_o  out  1  vector op in progress
done_o  out  1  one-cycle completion pulse
vrf_req_i  in  1  store data valid from VRF
vrf_data_i  in  32  store data
vrf_gnt_o  out  1  store element consumed
vrf_wvalid_o  out  1  load data valid to VRF
vrf_wdata_o  out  32  load data
scalar_req_i  in  1  scalar request
scalar_we_i  in  1  scalar write enable
scalar_addr_i  in  32  scalar address
scalar_wdata_i  in  32  scalar store data
scalar_gnt_o  out  1  scalar grant
scalar_rvalid_o  out  1  scalar response valid
lsu_req_o  out  1  request to LSU
lsu_we_o  out  1  write enable to LSU
lsu_addr_o  out  32  address to LSU
lsu_wdata_o  out  32  store data to LSU
lsu_gnt_i  in  1  LSU grant
lsu_rvalid_i  in  1  LSU response valid
lsu_rdata_i  in  32  LSU read data

Behaviour:
- Reset: state IDLE; addr, issued count, outstanding count, scalar_pending = 0; busy_o, done_o, lsu_req_o, vrf_*, scalar_gnt_o, scalar_rvalid_o = 0. Reset mid-op aborts immediately; in-flight responses after reset are not tracked.
- States IDLE, WAIT_SCALAR, ISSUE, DRAIN. busy_o=1 in all but IDLE.
- IDLE: lsu_* = scalar_*; scalar_gnt_o = lsu_gnt_i; scalar_rvalid_o = lsu_rvalid_i. scalar_pending set on scalar grant, cleared on rvalid (set wins if both same cycle).
- start_i in IDLE: latch start_addr_i, stride, strided, vl, is_store. vl==0 -> done_o pulse next cycle, stay IDLE. Else scalar_pending (or scalar grant this cycle) -> WAIT_SCALAR, else ISSUE. Scalar requests blocked (scalar_gnt_o=0) outside IDLE and in the start cycle. start_i outside IDLE ignored.
- WAIT_SCALAR: forward the pending scalar response as scalar_rvalid_o; on it -> ISSUE.
- ISSUE: lsu_addr_o=addr_q, lsu_we_o=is_store. lsu_req_o = (outstanding < MaxOutstanding) && (load || vrf_req_i). lsu_wdata_o=vrf_data_i; vrf_gnt_o = lsu_req_o && lsu_gnt_i && store.
- On grant: addr_q += strided ? stride : ElemBytes, modulo 2**32 (wrap, no error); issued++. Grant of last element (issued==vl-1) -> DRAIN.
- Outstanding: +1 on grant, -1 on lsu_rvalid_i, net 0 if both same cycle. Never exceeds MaxOutstanding, never underflows (rvalid with count 0 ignored, assertion fires).
- Loads: vrf_wvalid_o = lsu_rvalid_i (combinational, 0-cycle), vrf_wdata_o = lsu_rdata_i, in order. Stores: vrf_wvalid_o=0.
- DRAIN: no requests; when outstanding reaches 0 (incl. same-cycle last rvalid) -> IDLE, done_o=1 for exactly one cycle on that transition (registered).
- Max throughput 1 element/cycle when LSU grants every cycle and responds with latency <= MaxOutstanding.

Decomposition:
- Package vcve2_vlsu_pkg: state enum, mode typedef, ElemBytes default constant.
- Sub-module vcve2_vlsu_outstanding_cnt: saturating up/down in-flight counter with full/empty flags, width $clog2(MaxOutstanding+1).

Test Plan:
- Unit-stride load, base 0x1000, vl=4, gnt every cycle, rvalid 1 cycle later -> addresses 0x1000/04/08/0C, 4 vrf_wvalid_o, done_o one cycle after last rvalid.
- Strided store, base 0x2000, stride -8, vl=3, vrf_req_i toggling -> addresses 0x2000, 0x1FF8, 0x1FF0 only when vrf_req_i=1; vrf_gnt_o exactly 3.
- Backpressure: MaxOutstanding=2, rvalid delayed 5 cycles -> lsu_req_o drops after 2 grants, resumes on each rvalid; count never >2.
- Scalar grant in cycle N, start_i in N+1 -> WAIT_SCALAR, scalar_rvalid_o delivered, then vector issue; scalar_req_i during op gets no grant.
- vl=0 -> no lsu_req_o, done_o in next cycle. Base 0xFFFFFFFC, vl=2 -> second address 0x00000000.
- rst_ni low mid-ISSUE -> all outputs 0 asynchronously, IDLE after release, next scalar request passes through.
